// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package clkdiv_pkg;

    localparam int unsigned MIN_DIV = 2;

    // Divisors below MIN_DIV make no sense for a 50% clock; clamp them.
    function automatic int unsigned sat_div(input int unsigned d);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

    function automatic int unsigned half_ceil(input int unsigned d);
        return (d >> 1) + (d & 32'd1);
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: active/pending divisor, period counter, registered outputs.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_div,
    output logic             pend,
    output logic             div_out,
    output logic             tick
);

    logic [DIV_W-1:0] d;
    logic [DIV_W-1:0] p;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_nxt;
    logic [DIV_W-1:0] d_use;
    logic [DIV_W-1:0] half;
    logic             run;
    logic             wrap;
    logic             swap;

    // A pending divisor is swapped in only at a period boundary or while parked.
    always_comb begin
        run   = en & ~sync;
        wrap  = (cnt == d - DIV_W'(1));
        swap  = pend & (~run | wrap);
        d_use = swap ? p : d;
        half  = DIV_W'(half_ceil(32'(d_use)));
        if (!run) begin
            cnt_nxt = d_use - DIV_W'(1);
        end else if (wrap) begin
            cnt_nxt = '0;
        end else begin
            cnt_nxt = cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d       <= DIV_W'(DEFAULT_DIV);
            p       <= DIV_W'(DEFAULT_DIV);
            cnt     <= DIV_W'(DEFAULT_DIV - 1);
            pend    <= 1'b0;
            div_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            d       <= d_use;
            cnt     <= cnt_nxt;
            div_out <= run & (cnt_nxt < half);
            tick    <= run & (cnt_nxt == d_use - DIV_W'(1));
            if (swap) begin
                pend <= 1'b0;
            end
            // Writes are only accepted with pend clear, so never collide with swap.
            if (wr) begin
                p    <= DIV_W'(sat_div(32'(wr_div)));
                pend <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/prog_clk_divider.sv
// Multi-channel programmable divider: config handshake decode around NCH channels.
module prog_clk_divider
    import clkdiv_pkg::*;
#(
    parameter  int unsigned NCH         = 4,
    parameter  int unsigned DIV_W       = 8,
    parameter  int unsigned DEFAULT_DIV = 2,
    localparam int unsigned CH_W        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [NCH-1:0]   en,
    input  logic             sync,
    output logic [NCH-1:0]   div_out,
    output logic [NCH-1:0]   tick
);

    logic [NCH-1:0] pend;
    logic [NCH-1:0] wr;

    // Out-of-range channels are always ready so their writes drain harmlessly.
    always_comb begin
        cfg_ready = 1'b1;
        wr        = '0;
        for (int i = 0; i < NCH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = ~pend[i];
            end
        end
        for (int i = 0; i < NCH; i++) begin
            wr[i] = cfg_valid & cfg_ready & (cfg_ch == CH_W'(i));
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        clkdiv_channel #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (en[g]),
            .sync    (sync),
            .wr      (wr[g]),
            .wr_div  (cfg_div),
            .pend    (pend[g]),
            .div_out (div_out[g]),
            .tick    (tick[g])
        );
    end

endmodule

// File: tb/tb_prog_clk_divider.sv
// Self-checking bench: period-level reference model plus directed literal checks.
module tb_prog_clk_divider;

    localparam int NCH = 4;
    localparam int DEF = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_div;
    logic [3:0] en;
    logic       sync;
    logic       cfg_ready;
    logic [3:0] div_out;
    logic [3:0] tick;

    // Second instance with NCH=3 so an out-of-range channel index exists.
    logic       cfg_valid2;
    logic [1:0] cfg_ch2;
    logic [7:0] cfg_div2;
    logic [2:0] en2;
    logic       cfg_ready2;
    logic [2:0] div_out2;
    logic [2:0] tick2;

    always #5 clk = ~clk;

    prog_clk_divider #(.NCH(4), .DIV_W(8), .DEFAULT_DIV(DEF)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .en(en), .sync(sync),
        .div_out(div_out), .tick(tick)
    );

    prog_clk_divider #(.NCH(3), .DIV_W(8), .DEFAULT_DIV(DEF)) dut2 (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid2), .cfg_ready(cfg_ready2),
        .cfg_ch(cfg_ch2), .cfg_div(cfg_div2), .en(en2), .sync(1'b0),
        .div_out(div_out2), .tick(tick2)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_on   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: phase within current period, -1 while parked.
    int         m_d[NCH];
    int         m_p[NCH];
    int         m_ph[NCH];
    bit         m_pend[NCH];
    logic [3:0] m_div  = '0;
    logic [3:0] m_tick = '0;
    bit         m_acc;
    bit         m_run;

    function automatic bit m_ready(input int ch);
        if (ch >= NCH) return 1'b1;
        return !m_pend[ch];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                m_d[i] = DEF; m_p[i] = DEF; m_ph[i] = -1; m_pend[i] = 1'b0;
            end
            m_div  = '0;
            m_tick = '0;
        end else begin
            m_acc = cfg_valid && m_ready(int'(cfg_ch));
            for (int i = 0; i < NCH; i++) begin
                m_run = en[i] && !sync;
                if (!m_run) begin
                    if (m_pend[i]) begin m_d[i] = m_p[i]; m_pend[i] = 1'b0; end
                    m_ph[i] = -1;
                end else if (m_ph[i] == -1 || m_ph[i] == m_d[i] - 1) begin
                    if (m_pend[i]) begin m_d[i] = m_p[i]; m_pend[i] = 1'b0; end
                    m_ph[i] = 0;
                end else begin
                    m_ph[i] = m_ph[i] + 1;
                end
                m_div[i]  = m_run && (m_ph[i] < (m_d[i] + 1) / 2);
                m_tick[i] = m_run && (m_ph[i] == m_d[i] - 1);
            end
            if (m_acc && int'(cfg_ch) < NCH) begin
                m_p[cfg_ch]    = (cfg_div < 2) ? 2 : int'(cfg_div);
                m_pend[cfg_ch] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("div_out", 32'(div_out), 32'(m_div));
            chk("tick", 32'(tick), 32'(m_tick));
            chk("cfg_ready", 32'(cfg_ready), 32'(m_ready(int'(cfg_ch))));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic write(input int ch, input int dv);
        cfg_valid = 1'b1; cfg_ch = 2'(ch); cfg_div = 8'(dv);
        cyc();
        cfg_valid = 1'b0;
    endtask

    // Cycles from a tick (current or next) to the following tick; -1 on timeout.
    task automatic tick_interval(input int ch, output int n);
        int k;
        k = 0;
        while (!tick[ch] && k < 64) begin cyc(); k++; end
        if (k >= 64) begin n = -1; return; end
        n = 0;
        do begin cyc(); n++; end while (!tick[ch] && n < 64);
        if (!tick[ch]) n = -1;
    endtask

    int n;
    int k;

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; en = '0; sync = 1'b0;
        cfg_valid2 = 1'b0; cfg_ch2 = '0; cfg_div2 = '0; en2 = '0;
        cyc(); cyc(); cyc();
        chk_on = 1'b1;
        chk("reset div_out", 32'(div_out), 32'h0);
        chk("reset tick", 32'(tick), 32'h0);
        chk("reset cfg_ready", 32'(cfg_ready), 32'h1);
        rst = 1'b0;
        cyc();

        // Default D=2 on ch0; dut2 gets a write to nonexistent ch3.
        en = 4'b0001; en2 = 3'b001;
        cfg_valid2 = 1'b1; cfg_ch2 = 2'd3; cfg_div2 = 8'd9;
        #1 chk("oob cfg_ready2", 32'(cfg_ready2), 32'h1);
        for (int i = 0; i < 6; i++) begin
            cyc();
            cfg_valid2 = 1'b0;
            chk("d2 div_out[0]", 32'(div_out[0]), 32'(i % 2 == 0));
            chk("d2 tick[0]", 32'(tick[0]), 32'(i % 2 == 1));
            chk("dut2 div_out", 32'(div_out2), 32'(i % 2 == 0));
        end
        chk("idle channels", 32'(div_out[3:1]), 32'h0);
        chk("oob cfg_ready2 after", 32'(cfg_ready2), 32'h1);

        // ch1 at D=5: 3 high, 2 low, tick in the last low cycle.
        write(1, 5);
        en = 4'b0011;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("d5 div_out[1]", 32'(div_out[1]), 32'((i % 5) < 3));
            chk("d5 tick[1]", 32'(tick[1]), 32'((i % 5) == 4));
        end

        // ch0 to D=4, then D=6 mid-period; second write must stall.
        write(0, 4);
        repeat (8) cyc();
        k = 0;
        while (m_ph[0] != 1 && k < 20) begin cyc(); k++; end
        write(0, 6);
        cfg_valid = 1'b1; cfg_div = 8'd3;
        #1 chk("stall cfg_ready", 32'(cfg_ready), 32'h0);
        cyc();
        cfg_valid = 1'b0;
        tick_interval(0, n);
        chk("new period D=6", 32'(n), 32'd6);

        // Divisors 0 and 1 saturate to 2.
        write(2, 0);
        en = 4'b0111;
        tick_interval(2, n);
        chk("sat div0", 32'(n), 32'd2);
        write(3, 1);
        en = 4'b1111;
        tick_interval(3, n);
        chk("sat div1", 32'(n), 32'd2);

        // Back-to-back writes, then sync aligns D=3,4,7.
        en = 4'b0111;
        cfg_valid = 1'b1;
        cfg_ch = 2'd0; cfg_div = 8'd3; cyc();
        cfg_ch = 2'd1; cfg_div = 8'd4; cyc();
        cfg_ch = 2'd2; cfg_div = 8'd7; cyc();
        cfg_valid = 1'b0;
        repeat (20) cyc();
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        chk("sync park", 32'(div_out), 32'h0);
        cyc();
        chk("sync aligned rise", 32'(div_out), 32'h7);
        cyc(); cyc();
        chk("sync tick ch0", 32'(tick), 32'h1);
        cyc();
        chk("sync tick ch1", 32'(tick), 32'h2);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom % 200) == 0;
            if ($urandom % 8 == 0) en = 4'($urandom);
            sync = ($urandom % 40) == 0;
            cfg_valid = ($urandom % 3) == 0;
            cfg_ch = 2'($urandom);
            cfg_div = ($urandom % 4 == 0) ? 8'($urandom % 3) : 8'($urandom_range(2, 12));
            cyc();
        end

        // Reset with a pending write discards it.
        rst = 1'b0; sync = 1'b0; cfg_valid = 1'b0; en = 4'b1111;
        write(2, 12);
        repeat (3) cyc();
        cfg_ch = 2'd2;
        k = 0;
        while (m_pend[2] && k < 40) begin cyc(); k++; end
        write(2, 9);
        #1 chk("pend before rst", 32'(cfg_ready), 32'h0);
        rst = 1'b1;
        cyc();
        chk("rst div_out", 32'(div_out), 32'h0);
        chk("rst tick", 32'(tick), 32'h0);
        chk("rst cfg_ready", 32'(cfg_ready), 32'h1);
        rst = 1'b0; en = 4'b0100;
        tick_interval(2, n);
        chk("rst default D", 32'(n), 32'(DEF));

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
